// File: rtl/centroid_pkg.sv
// Shared geometry, datapath widths, FSM encoding and the coordinate clamp
// used by the centroid tracker and its divider.
package centroid_pkg;

  localparam int IMG_W_DEF = 1280;
  localparam int IMG_H_DEF = 720;
  localparam int COORD_W   = 11;
  localparam int SUM_W     = 32;
  localparam int CNT_W     = 20;

  typedef enum logic [1:0] {
    ACCUM  = 2'd0,
    DIV    = 2'd1,
    UPDATE = 2'd2
  } state_e;

  // Saturate a quotient to the last valid coordinate of the image
  function automatic logic [COORD_W-1:0] clamp_coord(input logic [SUM_W-1:0] q,
                                                     input int unsigned      lim);
    logic [SUM_W-1:0] lim_w;
    lim_w = SUM_W'(lim);
    return (q > lim_w) ? lim_w[COORD_W-1:0] : q[COORD_W-1:0];
  endfunction

endpackage

// File: rtl/centroid_div.sv
// 32-step restoring divider. Dividend and divisor are read every iteration,
// so the caller must hold them stable from start until done.
module centroid_div
  import centroid_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [SUM_W-1:0] dividend,
  input  logic [CNT_W-1:0] divisor,
  output logic [SUM_W-1:0] quotient,
  output logic             done
);

  localparam logic [4:0] MSB = 5'(SUM_W - 1);

  logic             run_q, run_d;
  logic [4:0]       step_q, step_d;
  logic [CNT_W-1:0] rem_q, rem_d;
  logic [SUM_W-1:0] quo_q, quo_d;
  logic             done_q, done_d;
  logic [CNT_W:0]   trial;
  logic [CNT_W:0]   diff;

  always_comb begin
    run_d  = run_q;
    step_d = step_q;
    rem_d  = rem_q;
    quo_d  = quo_q;
    done_d = 1'b0;
    trial  = {rem_q, dividend[MSB - step_q]};
    diff   = trial - {1'b0, divisor};
    if (start) begin
      run_d  = 1'b1;
      step_d = '0;
      rem_d  = '0;
      quo_d  = '0;
    end else if (run_q) begin
      // Remainder stays below the divisor, so the restored value fits CNT_W bits
      if (trial >= {1'b0, divisor}) begin
        rem_d = diff[CNT_W-1:0];
        quo_d = {quo_q[SUM_W-2:0], 1'b1};
      end else begin
        rem_d = trial[CNT_W-1:0];
        quo_d = {quo_q[SUM_W-2:0], 1'b0};
      end
      step_d = step_q + 5'd1;
      if (step_q == MSB) begin
        run_d  = 1'b0;
        done_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_q  <= 1'b0;
      step_q <= '0;
      rem_q  <= '0;
      quo_q  <= '0;
      done_q <= 1'b0;
    end else begin
      run_q  <= run_d;
      step_q <= step_d;
      rem_q  <= rem_d;
      quo_q  <= quo_d;
      done_q <= done_d;
    end
  end

  assign quotient = quo_q;
  assign done     = done_q;

endmodule

// File: rtl/centroid_tracker.sv
// Accumulates masked pixel coordinates per frame and, at each frame end,
// divides the sums by the pixel count to publish the object centroid.
module centroid_tracker
  import centroid_pkg::*;
#(
  parameter int IMG_W = IMG_W_DEF,
  parameter int IMG_H = IMG_H_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               de,
  input  logic               hsync,
  input  logic               vsync,
  input  logic               mask_in,
  output logic [COORD_W-1:0] x_center,
  output logic [COORD_W-1:0] y_center,
  output logic               center_valid,
  output logic               busy
);

  state_e             state_q, state_d;
  logic [COORD_W-1:0] x_pos_q, x_pos_d, y_pos_q, y_pos_d;
  logic [SUM_W-1:0]   sum_x_q, sum_x_d, sum_y_q, sum_y_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [SUM_W-1:0]   snap_x_q, snap_x_d, snap_y_q, snap_y_d;
  logic [CNT_W-1:0]   snap_n_q, snap_n_d;
  logic               vs_q, vs_prev_q;
  logic [COORD_W-1:0] x_center_q, x_center_d, y_center_q, y_center_d;
  logic               center_valid_q, center_valid_d;
  logic               frame_end, pix_hit, launch;
  logic [SUM_W-1:0]   quo_x, quo_y;
  logic               done_x, done_y;
  logic               unused_hsync;

  assign unused_hsync = hsync;
  assign frame_end    = vs_q & ~vs_prev_q;
  assign pix_hit      = ~vsync & de & mask_in;
  assign launch       = frame_end && (state_q == ACCUM) && (count_q != '0);

  always_comb begin
    x_pos_d = x_pos_q;
    y_pos_d = y_pos_q;
    if (vsync) begin
      x_pos_d = '0;
      y_pos_d = '0;
    end else if (de) begin
      if (x_pos_q == COORD_W'(IMG_W - 1)) begin
        x_pos_d = '0;
        y_pos_d = (y_pos_q == COORD_W'(IMG_H - 1)) ? '0 : y_pos_q + COORD_W'(1);
      end else begin
        x_pos_d = x_pos_q + COORD_W'(1);
      end
    end
  end

  // Accumulators clear on every frame end, even when the frame is dropped
  always_comb begin
    sum_x_d = sum_x_q;
    sum_y_d = sum_y_q;
    count_d = count_q;
    if (frame_end) begin
      sum_x_d = '0;
      sum_y_d = '0;
      count_d = '0;
    end else if (pix_hit) begin
      sum_x_d = sum_x_q + SUM_W'(x_pos_q);
      sum_y_d = sum_y_q + SUM_W'(y_pos_q);
      count_d = count_q + CNT_W'(1);
    end
  end

  always_comb begin
    state_d        = state_q;
    snap_x_d       = snap_x_q;
    snap_y_d       = snap_y_q;
    snap_n_d       = snap_n_q;
    x_center_d     = x_center_q;
    y_center_d     = y_center_q;
    center_valid_d = 1'b0;
    case (state_q)
      ACCUM: begin
        if (launch) begin
          state_d  = DIV;
          snap_x_d = sum_x_q;
          snap_y_d = sum_y_q;
          snap_n_d = count_q;
        end
      end
      DIV: begin
        if (done_x && done_y) begin
          state_d        = UPDATE;
          x_center_d     = clamp_coord(quo_x, IMG_W - 1);
          y_center_d     = clamp_coord(quo_y, IMG_H - 1);
          center_valid_d = 1'b1;
        end
      end
      UPDATE:  state_d = ACCUM;
      default: state_d = ACCUM;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= ACCUM;
      x_pos_q        <= '0;
      y_pos_q        <= '0;
      sum_x_q        <= '0;
      sum_y_q        <= '0;
      count_q        <= '0;
      snap_x_q       <= '0;
      snap_y_q       <= '0;
      snap_n_q       <= '0;
      vs_q           <= 1'b0;
      vs_prev_q      <= 1'b0;
      x_center_q     <= '0;
      y_center_q     <= '0;
      center_valid_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      x_pos_q        <= x_pos_d;
      y_pos_q        <= y_pos_d;
      sum_x_q        <= sum_x_d;
      sum_y_q        <= sum_y_d;
      count_q        <= count_d;
      snap_x_q       <= snap_x_d;
      snap_y_q       <= snap_y_d;
      snap_n_q       <= snap_n_d;
      vs_q           <= vsync;
      vs_prev_q      <= vs_q;
      x_center_q     <= x_center_d;
      y_center_q     <= y_center_d;
      center_valid_q <= center_valid_d;
    end
  end

  centroid_div u_div_x (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (launch),
    .dividend (snap_x_q),
    .divisor  (snap_n_q),
    .quotient (quo_x),
    .done     (done_x)
  );

  centroid_div u_div_y (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (launch),
    .dividend (snap_y_q),
    .divisor  (snap_n_q),
    .quotient (quo_y),
    .done     (done_y)
  );

  assign x_center     = x_center_q;
  assign y_center     = y_center_q;
  assign center_valid = center_valid_q;
  assign busy         = (state_q == DIV);

endmodule

// File: tb/tb_centroid_tracker.sv
// Directed and randomized frames against a per-frame sum/count reference model.
module tb_centroid_tracker;

  localparam int W = 160;
  localparam int H = 96;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        de = 1'b0;
  logic        hsync = 1'b0;
  logic        vsync = 1'b1;
  logic        mask_in = 1'b0;
  logic [10:0] x_center;
  logic [10:0] y_center;
  logic        center_valid;
  logic        busy;

  int     total = 0;
  int     bad = 0;
  int     k_cnt = 0;
  int     pulse_n = 0;
  int     pulse_at = 0;
  int     pidx = 0;
  longint msx = 0;
  longint msy = 0;
  longint mn = 0;
  longint exp_x = 0;
  longint exp_y = 0;

  centroid_tracker #(.IMG_W(W), .IMG_H(H)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .de           (de),
    .hsync        (hsync),
    .vsync        (vsync),
    .mask_in      (mask_in),
    .x_center     (x_center),
    .y_center     (y_center),
    .center_valid (center_valid),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv)
    else begin
      bad++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, expv);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    k_cnt++;
    if (center_valid === 1'b1) begin
      pulse_n++;
      pulse_at = k_cnt;
    end
  endtask

  task automatic model_clear();
    msx  = 0;
    msy  = 0;
    mn   = 0;
    pidx = 0;
  endtask

  task automatic pix(input bit d, input bit m);
    vsync   = 1'b0;
    de      = d;
    mask_in = m;
    if (d) begin
      if (m) begin
        msx += pidx % W;
        msy += (pidx / W) % H;
        mn++;
      end
      pidx++;
    end
    step();
  endtask

  // dens: 0 none, 1 full rectangle, 2 random pixels inside the rectangle
  task automatic stream(input int npix, input int x0, input int x1, input int y0,
                        input int y1, input int dens, input bit gaps);
    int done_px;
    int cx;
    int cy;
    bit m;
    done_px = 0;
    while (done_px < npix) begin
      if (gaps && $urandom_range(3) == 0) begin
        pix(1'b0, 1'($urandom_range(1)));
      end else begin
        cx = pidx % W;
        cy = (pidx / W) % H;
        m  = (cx >= x0) && (cx <= x1) && (cy >= y0) && (cy <= y1) &&
             ((dens == 1) || ((dens == 2) && ($urandom_range(1) == 1)));
        pix(1'b1, m);
        done_px++;
      end
    end
  endtask

  function automatic void compute_expected();
    if (mn != 0) begin
      exp_x = msx / mn;
      exp_y = msy / mn;
      if (exp_x > W - 1) exp_x = W - 1;
      if (exp_y > H - 1) exp_y = H - 1;
    end
  endfunction

  task automatic frame_end(input string tag);
    bit   expect_p;
    logic busy_mid;
    expect_p = (mn != 0);
    compute_expected();
    vsync    = 1'b1;
    de       = 1'b0;
    mask_in  = 1'b0;
    busy_mid = 1'b0;
    step();
    k_cnt    = 0;
    pulse_n  = 0;
    pulse_at = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (k_cnt == 10) busy_mid = busy;
    end
    chk({tag, "/pulse_n"}, pulse_n, expect_p ? 1 : 0);
    chk({tag, "/pulse_at"}, pulse_at, expect_p ? 34 : 0);
    chk({tag, "/x_center"}, x_center, 32'(exp_x));
    chk({tag, "/y_center"}, y_center, 32'(exp_y));
    chk({tag, "/busy"}, busy_mid, expect_p);
    model_clear();
  endtask

  initial begin
    repeat (3) step();
    chk("rst/x_center", x_center, 0);
    chk("rst/y_center", y_center, 0);
    chk("rst/center_valid", center_valid, 0);
    chk("rst/busy", busy, 0);
    rst_n = 1'b1;
    repeat (3) step();
    model_clear();

    stream(51 * W, 100, 100, 50, 50, 1, 1'b0);
    frame_end("single");

    stream(22 * W, 10, 11, 20, 21, 1, 1'b0);
    chk("block/sum_x", 32'(msx), 42);
    frame_end("block");

    stream(W * H, 0, W - 1, 0, H - 1, 1, 1'b0);
    frame_end("full");

    stream(200, 0, W - 1, 0, H - 1, 0, 1'b1);
    frame_end("empty");

    // Reset while the divider is running
    stream(4 * W, 5, 7, 2, 3, 1, 1'b0);
    vsync = 1'b1;
    de    = 1'b0;
    step();
    k_cnt = 0;
    repeat (11) step();
    chk("rstdiv/busy_before", busy, 1);
    rst_n = 1'b0;
    #1;
    chk("rstdiv/x_center", x_center, 0);
    chk("rstdiv/y_center", y_center, 0);
    chk("rstdiv/center_valid", center_valid, 0);
    chk("rstdiv/busy", busy, 0);
    repeat (3) step();
    rst_n   = 1'b1;
    pulse_n = 0;
    repeat (40) step();
    chk("rstdiv/no_pulse", pulse_n, 0);
    exp_x = 0;
    exp_y = 0;
    model_clear();
    stream(5 * W, 20, 30, 1, 4, 2, 1'b1);
    frame_end("after_rst");

    // Second frame end while dividing is dropped
    stream(3 * W, 60, 70, 1, 2, 1, 1'b0);
    compute_expected();
    model_clear();
    vsync = 1'b1;
    de    = 1'b0;
    step();
    k_cnt    = 0;
    pulse_n  = 0;
    pulse_at = 0;
    repeat (2) step();
    pix(1'b1, 1'b1);
    pix(1'b1, 1'b1);
    pix(1'b1, 1'b1);
    vsync   = 1'b1;
    de      = 1'b0;
    mask_in = 1'b0;
    while (k_cnt < 40) step();
    chk("drop/pulse_n", pulse_n, 1);
    chk("drop/pulse_at", pulse_at, 34);
    chk("drop/x_center", x_center, 32'(exp_x));
    chk("drop/y_center", y_center, 32'(exp_y));
    model_clear();
    stream(4 * W, 40, 42, 3, 3, 1, 1'b0);
    frame_end("after_drop");

    for (int r = 0; r < 4; r++) begin
      int x0;
      int y0;
      int h;
      x0 = $urandom_range(W - 8);
      y0 = $urandom_range(6);
      h  = $urandom_range(1, 4);
      stream((y0 + h) * W + $urandom_range(50), x0, x0 + $urandom_range(7),
             y0, y0 + h - 1, 2, 1'b1);
      frame_end($sformatf("rand%0d", r));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
